ifu_fetch_fsm: RTL

Multi-cycle instruction fetch stage that sits directly upstream of the decode/execute datapath. It holds the architectural PC and issues one instruction read at a time over an AXI4-Lite-style read channel (AR/R). It presents the fetched word to the consumer with a valid/ready handshake, then waits for the consumer to return the next PC before fetching again. Exactly one fetch is outstanding at any time; misaligned PCs and bus errors are reported as faults instead of stalling.

---
 rtl/ifu_fetch_fsm.sv | 80 ++++++++
 1 files changed

// File: rtl/ifu_fetch_fsm.sv
// ifu_fetch_fsm: single-outstanding instruction fetch with AR/R read channel and valid/ready delivery
module ifu_fetch_fsm #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_next_valid,
   input  logic [31:0] pc_next,
   output logic        pc_next_ready,
   output logic        mem_arvalid,
   output logic [31:0] mem_araddr,
   input  logic        mem_arready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_rresp,
   output logic        mem_rready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready,
   output logic [31:0] fetch_cnt
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_R, HOLD, WAIT_PC} state_t;
   state_t state, state_nx;
   logic [31:0] pc;
   logic ar_hs, r_hs, inst_hs, pc_hs, pc_misaligned;
   assign mem_arvalid   = state == REQ;
   assign mem_rready    = state == WAIT_R;
   assign inst_valid    = state == HOLD;
   assign pc_next_ready = state == WAIT_PC;
   assign mem_araddr    = pc;
   assign ar_hs         = mem_arvalid & mem_arready;
   assign r_hs          = mem_rready & mem_rvalid;
   assign inst_hs       = inst_valid & inst_ready;
   assign pc_hs         = pc_next_ready & pc_next_valid;
   assign pc_misaligned = pc_next[1:0] != 2'b00;
   // State register; reset drops every valid/ready output at once since they decode from state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // Next-state: each state advances only on its own handshake, other inputs are ignored
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = REQ;
         REQ:     state_nx = ar_hs ? WAIT_R : REQ;
         WAIT_R:  state_nx = r_hs ? HOLD : WAIT_R;
         HOLD:    state_nx = inst_hs ? WAIT_PC : HOLD;
         WAIT_PC: state_nx = pc_hs ? (pc_misaligned ? HOLD : REQ) : WAIT_PC;
         default: state_nx = IDLE;
      endcase
   end
   // Datapath: capture responses, count deliveries, take the redirect PC or report it as a fault
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_fault <= 1'b0;
         fetch_cnt  <= 32'h0;
      end else begin
         if (r_hs) begin
            inst       <= (mem_rresp == 2'b00) ? mem_rdata : 32'h0;
            inst_fault <= mem_rresp != 2'b00;
            inst_pc    <= pc;
         end
         if (inst_hs) fetch_cnt <= fetch_cnt + 32'd1;
         if (pc_hs) begin
            pc <= pc_next;
            if (pc_misaligned) begin
               inst       <= 32'h0;
               inst_fault <= 1'b1;
               inst_pc    <= pc_next;
            end
         end
      end
   end
endmodule
